// File: rtl/hs_tx_ctrl_if.sv
// Handshake bundle between the local producer, hs_tx_ctrl and the remote receiver.
// The slave modport is the controller's view; the master modport is the environment's.
interface hs_tx_ctrl_if #(
    parameter int BUS_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] IN_DATA;
    logic                 IN_VALID;
    logic                 IN_READY;
    logic [BUS_WIDTH-1:0] OUT_DATA;
    logic                 OUT_REQ;
    logic                 ACK_ASYNC;
    logic                 BUSY;
    logic                 DONE;
    logic                 TIMEOUT_ERR;

    modport slave (
        input  IN_DATA, IN_VALID, ACK_ASYNC,
        output IN_READY, OUT_DATA, OUT_REQ, BUSY, DONE, TIMEOUT_ERR
    );

    modport master (
        output IN_DATA, IN_VALID, ACK_ASYNC,
        input  IN_READY, OUT_DATA, OUT_REQ, BUSY, DONE, TIMEOUT_ERR
    );
endinterface

// File: rtl/hs_tx_ctrl.sv
// Source side of a 4-phase req/ack crossing: captures one producer word, holds it on
// OUT_DATA and sequences OUT_REQ against a locally synchronized remote acknowledge.
module hs_tx_ctrl #(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int TIMEOUT    = 255,
    parameter int CNT_WIDTH  = 8
) (
    input  logic         CLK,
    input  logic         RST,
    hs_tx_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ_HI, ACK_LO} state_t;

    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t                state;
    logic [NUM_STAGES-1:0] ack_pipe;
    logic                  ack_sync;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [BUS_WIDTH-1:0]  out_data;
    logic                  out_req;
    logic                  done;
    logic                  tmo_err;
    logic                  timed_out;
    logic                  in_ready;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) ack_pipe <= '0;
        else      ack_pipe <= {ack_pipe[NUM_STAGES-2:0], bus.ACK_ASYNC};
    end

    assign ack_sync = ack_pipe[NUM_STAGES-1];
    // A stale high acknowledge from the previous transfer must clear before a new word is taken.
    assign in_ready = (state == IDLE) && !ack_sync;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            out_data  <= '0;
            out_req   <= 1'b0;
            done      <= 1'b0;
            tmo_err   <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            done    <= 1'b0;
            tmo_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.IN_VALID && in_ready) begin
                        out_data <= bus.IN_DATA;
                        out_req  <= 1'b1;
                        cnt      <= '0;
                        state    <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (ack_sync) begin
                        out_req   <= 1'b0;
                        timed_out <= 1'b0;
                        state     <= ACK_LO;
                    end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
                        out_req   <= 1'b0;
                        tmo_err   <= 1'b1;
                        timed_out <= 1'b1;
                        state     <= ACK_LO;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK_LO: begin
                    // Wait out the remote's ack release even after an abort; no timeout here.
                    if (!ack_sync) begin
                        done  <= !timed_out;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.IN_READY    = in_ready;
    assign bus.BUSY        = (state != IDLE);
    assign bus.OUT_DATA    = out_data;
    assign bus.OUT_REQ     = out_req;
    assign bus.DONE        = done;
    assign bus.TIMEOUT_ERR = tmo_err;
endmodule
